// File: rtl/serial_port.sv
// serial_port: memory-mapped 8N1 UART for the Z8 external bus (7F10-7F13).
// TX: holding register feeding a shift register, gapless back-to-back frames.
// RX: 2-flop synchronizer, mid-bit sampling, buffered for the processor.
// Build option SERIAL_RX_FIFO_EN: RX buffer is a 2^rxDepthBits-entry FIFO;
// without it the RX buffer is a single holding register.
module serial_port #(
    parameter int clocksPerBit = 416,
    parameter int rxDepthBits  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] addr,
    input  logic [7:0] dataIn,
    output logic [7:0] dataOut,
    input  logic       strobe,
    input  logic       write,
    input  logic       serialIn,
    output logic       serialOut,
    output logic       irq
);

    localparam logic [11:0] BIT_LAST  = 12'(clocksPerBit - 1);
    localparam logic [11:0] HALF_LAST = 12'(clocksPerBit / 2 - 1);

    // bus decode: side effects only happen on the strobed edge
    logic rdData, rdStatus, wrData;
    assign rdData   = strobe && !write && (addr == 2'd0);
    assign rdStatus = strobe && !write && (addr == 2'd1);
    assign wrData   = strobe &&  write && (addr == 2'd0);

    // ---------------------------------------------------------------- TX
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    txState_t    txState, txStateNext;
    logic [11:0] txCnt, txCntNext;
    logic [2:0]  txBit, txBitNext;
    logic [7:0]  txShift, txShiftNext;
    logic        txOutNext, txTake;
    logic [7:0]  txHold;
    logic        txHoldFull;

    // holding register: loaded by the processor, emptied when the shifter takes it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txHold     <= 8'h00;
            txHoldFull <= 1'b0;
        end else if (txTake) begin
            txHoldFull <= 1'b0;
        end else if (wrData && !txHoldFull) begin
            txHold     <= dataIn;
            txHoldFull <= 1'b1;
        end
    end

    // TX state register; serialOut is registered from the next-state decode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txState   <= TX_IDLE;
            txCnt     <= 12'd0;
            txBit     <= 3'd0;
            txShift   <= 8'h00;
            serialOut <= 1'b1;
        end else begin
            txState   <= txStateNext;
            txCnt     <= txCntNext;
            txBit     <= txBitNext;
            txShift   <= txShiftNext;
            serialOut <= txOutNext;
        end
    end

    // TX next state: each bit lasts clocksPerBit cycles; STOP chains into START
    always_comb begin
        txStateNext = txState;
        txCntNext   = txCnt + 12'd1;
        txBitNext   = txBit;
        txShiftNext = txShift;
        txOutNext   = serialOut;
        txTake      = 1'b0;
        unique case (txState)
            TX_IDLE: begin
                txCntNext = 12'd0;
                txOutNext = 1'b1;
                if (txHoldFull) begin
                    txTake      = 1'b1;
                    txShiftNext = txHold;
                    txStateNext = TX_START;
                    txOutNext   = 1'b0;
                end
            end
            TX_START: if (txCnt == BIT_LAST) begin
                txCntNext   = 12'd0;
                txBitNext   = 3'd0;
                txStateNext = TX_DATA;
                txOutNext   = txShift[0];
            end
            TX_DATA: if (txCnt == BIT_LAST) begin
                txCntNext = 12'd0;
                if (txBit == 3'd7) begin
                    txStateNext = TX_STOP;
                    txOutNext   = 1'b1;
                end else begin
                    txBitNext   = txBit + 3'd1;
                    txShiftNext = {1'b0, txShift[7:1]};
                    txOutNext   = txShift[1];
                end
            end
            TX_STOP: if (txCnt == BIT_LAST) begin
                txCntNext = 12'd0;
                if (txHoldFull) begin
                    txTake      = 1'b1;
                    txShiftNext = txHold;
                    txStateNext = TX_START;
                    txOutNext   = 1'b0;
                end else begin
                    txStateNext = TX_IDLE;
                    txOutNext   = 1'b1;
                end
            end
            default: txStateNext = TX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- RX
    // BREAK holds off after a framing error until the line returns high
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rxState_t;
    rxState_t    rxState, rxStateNext;
    logic [11:0] rxCnt, rxCntNext;
    logic [2:0]  rxBit, rxBitNext;
    logic [7:0]  rxShift, rxShiftNext;
    logic        rxSync1, rxSync2;
    logic        rxPush, rxPushNext, framingSet;

    // RX registers, including the 2-flop synchronizer and the push pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxSync1 <= 1'b1;
            rxSync2 <= 1'b1;
            rxState <= RX_IDLE;
            rxCnt   <= 12'd0;
            rxBit   <= 3'd0;
            rxShift <= 8'h00;
            rxPush  <= 1'b0;
        end else begin
            rxSync1 <= serialIn;
            rxSync2 <= rxSync1;
            rxState <= rxStateNext;
            rxCnt   <= rxCntNext;
            rxBit   <= rxBitNext;
            rxShift <= rxShiftNext;
            rxPush  <= rxPushNext;
        end
    end

    // RX next state: half-bit start qualification, then full-bit sampling
    always_comb begin
        rxStateNext = rxState;
        rxCntNext   = rxCnt + 12'd1;
        rxBitNext   = rxBit;
        rxShiftNext = rxShift;
        rxPushNext  = 1'b0;
        framingSet  = 1'b0;
        unique case (rxState)
            RX_IDLE: begin
                rxCntNext = 12'd0;
                if (!rxSync2) rxStateNext = RX_START;
            end
            RX_START: if (rxCnt == HALF_LAST) begin
                rxCntNext   = 12'd0;
                rxBitNext   = 3'd0;
                rxStateNext = rxSync2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rxCnt == BIT_LAST) begin
                rxCntNext   = 12'd0;
                rxShiftNext = {rxSync2, rxShift[7:1]};
                if (rxBit == 3'd7) rxStateNext = RX_STOP;
                else               rxBitNext   = rxBit + 3'd1;
            end
            RX_STOP: if (rxCnt == BIT_LAST) begin
                rxCntNext = 12'd0;
                if (rxSync2) begin
                    rxPushNext  = 1'b1;
                    rxStateNext = RX_IDLE;
                end else begin
                    framingSet  = 1'b1;
                    rxStateNext = RX_BREAK;
                end
            end
            RX_BREAK: begin
                rxCntNext = 12'd0;
                if (rxSync2) rxStateNext = RX_IDLE;
            end
            default: rxStateNext = RX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- RX buffer
    // rxShift is stable until the next frame's first data sample, so it is
    // the push data for the registered push pulse.
    logic [rxDepthBits:0] rxCount;
    logic [7:0]           rxHead;
    logic                 rxAvail, rxFull, rxPop, overrunSet;

    assign rxAvail = (rxCount != '0);

`ifdef SERIAL_RX_FIFO_EN
    localparam int RX_DEPTH = 1 << rxDepthBits;
    localparam logic [rxDepthBits:0] RX_FULL_COUNT = RX_DEPTH[rxDepthBits:0];
    logic [7:0]             rxMem [RX_DEPTH];
    logic [rxDepthBits-1:0] rxWrPtr, rxRdPtr;
    logic                   rxWrite;

    assign rxFull     = (rxCount == RX_FULL_COUNT);
    assign rxPop      = rdData && rxAvail;
    // a pop on the same edge makes room, so a full FIFO still accepts the push
    assign rxWrite    = rxPush && (!rxFull || rxPop);
    assign overrunSet = rxPush && rxFull && !rxPop;
    assign rxHead     = rxMem[rxRdPtr];

    // FIFO storage
    always_ff @(posedge clk) begin
        if (rxWrite) rxMem[rxWrPtr] <= rxShift;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxWrPtr <= '0;
            rxRdPtr <= '0;
            rxCount <= '0;
        end else begin
            if (rxWrite) rxWrPtr <= rxWrPtr + 1'b1;
            if (rxPop)   rxRdPtr <= rxRdPtr + 1'b1;
            if (rxWrite && !rxPop)      rxCount <= rxCount + 1'b1;
            else if (!rxWrite && rxPop) rxCount <= rxCount - 1'b1;
        end
    end
`else
    logic [7:0] rxHoldReg;
    logic       rxHoldValid;

    assign rxFull     = rxHoldValid;
    assign rxPop      = rdData && rxHoldValid;
    assign overrunSet = rxPush && rxHoldValid && !rxPop;
    assign rxHead     = rxHoldReg;
    assign rxCount    = {{rxDepthBits{1'b0}}, rxHoldValid};

    // single-entry RX holding register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxHoldReg   <= 8'h00;
            rxHoldValid <= 1'b0;
        end else if (rxPush && (!rxHoldValid || rxPop)) begin
            rxHoldReg   <= rxShift;
            rxHoldValid <= 1'b1;
        end else if (rxPop) begin
            rxHoldValid <= 1'b0;
        end
    end
`endif

    // ---------------------------------------------------------------- status
    logic overrun, framingErr;

    // sticky error bits; a new event wins over a clearing status read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun    <= 1'b0;
            framingErr <= 1'b0;
        end else begin
            if (overrunSet)    overrun <= 1'b1;
            else if (rdStatus) overrun <= 1'b0;
            if (framingSet)    framingErr <= 1'b1;
            else if (rdStatus) framingErr <= 1'b0;
        end
    end

    assign irq = rxAvail;

    // read mux
    always_comb begin
        dataOut = 8'h00;
        unique case (addr)
            2'd0:    dataOut = rxAvail ? rxHead : 8'h00;
            2'd1:    dataOut = {2'b00, framingErr, overrun, (txState == TX_IDLE),
                                !txHoldFull, rxFull, rxAvail};
            default: dataOut = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_serial_port.sv
// Directed bench for serial_port: TX frames decoded by a line monitor and
// matched against a byte scoreboard; RX bytes driven onto serialIn, expected
// bytes queued at send time and popped on addr-0 reads.
`timescale 1ns/1ps
module tb_serial_port;

    localparam int CPB = 416;
`ifdef SERIAL_RX_FIFO_EN
    localparam int RXCAP = 4;
    localparam logic [7:0] ST_ONE = 8'h0D;
`else
    localparam int RXCAP = 1;
    localparam logic [7:0] ST_ONE = 8'h0F;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] addr = 2'd0;
    logic [7:0] dataIn = 8'h00;
    logic [7:0] dataOut;
    logic       strobe = 1'b0;
    logic       write = 1'b0;
    logic       serialIn = 1'b1;
    logic       serialOut;
    logic       irq;

    serial_port #(.clocksPerBit(CPB), .rxDepthBits(2)) dut (
        .clk(clk), .reset(reset), .addr(addr), .dataIn(dataIn), .dataOut(dataOut),
        .strobe(strobe), .write(write), .serialIn(serialIn), .serialOut(serialOut),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] txExp[$];
    logic [7:0] rxExp[$];
    int         txStarts[$];
    int         txFrames = 0;
    bit         monEn = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // TX line monitor: samples each bit mid-cell and scores the decoded byte
    always begin : txMon
        logic [7:0] b;
        logic       s0, s1;
        int         t;
        @(negedge serialOut);
        if (reset === 1'b1) begin
            @(negedge clk);
            t = cyc;
            repeat (CPB / 2) @(posedge clk);
            @(negedge clk);
            s0 = serialOut;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                @(negedge clk);
                b[i] = serialOut;
            end
            repeat (CPB) @(posedge clk);
            @(negedge clk);
            s1 = serialOut;
            if (monEn) begin
                txFrames++;
                txStarts.push_back(t);
                check("tx_start_bit", s0, 1'b0);
                check("tx_stop_bit", s1, 1'b1);
                check("tx_pending", txExp.size() > 0, 1'b1);
                if (txExp.size() > 0) check("tx_byte", b, txExp.pop_front());
            end
        end
    end

    task automatic busRead(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; write = 1'b0; strobe = 1'b1;
        #1 d = dataOut;
        @(posedge clk);
        #1 strobe = 1'b0;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; write = 1'b1; dataIn = d; strobe = 1'b1;
        @(posedge clk);
        #1 strobe = 1'b0; write = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        busRead(a, d);
        check(tag, d, exp);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        @(posedge clk);
        #1 serialIn = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 serialIn = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 serialIn = stopBit;
        repeat (CPB) @(posedge clk);
        if (!stopBit) repeat (CPB) @(posedge clk);
        #1 serialIn = 1'b1;
    endtask

    task automatic waitTx(input int n, input int limit);
        int k = 0;
        while (txFrames < n && k < limit) begin
            @(posedge clk);
            k++;
        end
        check("tx_frames", txFrames, n);
    endtask

    task automatic waitIrq(input int limit);
        int k = 0;
        while (irq !== 1'b1 && k < limit) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        check("irq_rise", irq, 1'b1);
    endtask

    initial begin
        logic [7:0] d;
        // reset state
        #2 reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_serialOut", serialOut, 1'b1);
        check("rst_irq", irq, 1'b0);
        reset = 1'b1;
        readCheck("rst_status", 2'd1, 8'h0C);
        readCheck("empty_rx_read", 2'd0, 8'h00);
        readCheck("addr2_read", 2'd2, 8'h00);
        readCheck("addr3_read", 2'd3, 8'h00);
        busWrite(2'd1, 8'hFF);
        busWrite(2'd3, 8'hAA);
        readCheck("status_after_ignored_writes", 2'd1, 8'h0C);

        // single TX frame with latency check
        txExp.push_back(8'h55);
        busWrite(2'd0, 8'h55);
        check("tx_latency_hold", serialOut, 1'b1);
        @(posedge clk);
        #1 check("tx_latency_fall", serialOut, 1'b0);
        readCheck("tx_busy_status", 2'd1, 8'h04);
        waitTx(1, 12 * CPB);
        repeat (CPB) @(posedge clk);
        readCheck("tx_done_status", 2'd1, 8'h0C);

        // back-to-back TX, third write ignored while holding register full
        txExp.push_back(8'h11);
        txExp.push_back(8'h22);
        busWrite(2'd0, 8'h11);
        repeat (10) @(posedge clk);
        busWrite(2'd0, 8'h22);
        readCheck("tx_hold_full_status", 2'd1, 8'h00);
        busWrite(2'd0, 8'h33);
        waitTx(3, 24 * CPB);
        if (txStarts.size() >= 3) check("tx_gapless", txStarts[2] - txStarts[1], 10 * CPB);
        repeat (CPB) @(posedge clk);
        readCheck("tx_third_write_dropped", 2'd1, 8'h0C);
        check("tx_queue_drained", txExp.size(), 0);

        // RX single byte
        rxExp.push_back(8'hA5);
        sendByte(8'hA5, 1'b1);
        waitIrq(2 * CPB);
        readCheck("rx_avail_status", 2'd1, ST_ONE);
        readCheck("rx_byte_A5", 2'd0, rxExp.pop_front());
        check("rx_irq_clear", irq, 1'b0);
        readCheck("rx_empty_status", 2'd1, 8'h0C);

        // overrun: five bytes without reading
        for (int v = 1; v <= 5; v++) begin
            if (v <= RXCAP) rxExp.push_back(8'(v));
            sendByte(8'(v), 1'b1);
        end
        repeat (4) @(posedge clk);
        readCheck("overrun_status_set", 2'd1, 8'h1F);
        readCheck("overrun_status_clr", 2'd1, 8'h0F);
        for (int i = 0; i < RXCAP; i++) begin
            busRead(2'd0, d);
            check("overrun_rx_byte", d, rxExp.pop_front());
        end
        readCheck("overrun_drained_read", 2'd0, 8'h00);
        readCheck("overrun_drained_status", 2'd1, 8'h0C);

        // framing error then a normal byte
        sendByte(8'h3C, 1'b0);
        repeat (CPB) @(posedge clk);
        @(negedge clk);
        check("framing_no_irq", irq, 1'b0);
        readCheck("framing_status_set", 2'd1, 8'h2C);
        readCheck("framing_status_clr", 2'd1, 8'h0C);
        rxExp.push_back(8'h7E);
        sendByte(8'h7E, 1'b1);
        waitIrq(2 * CPB);
        readCheck("rx_byte_7E", 2'd0, rxExp.pop_front());
        readCheck("post_framing_status", 2'd1, 8'h0C);

        // reset mid TX frame with RX data pending
        sendByte(8'h81, 1'b1);
        waitIrq(2 * CPB);
        monEn = 1'b0;
        busWrite(2'd0, 8'h5A);
        repeat (3 * CPB + CPB / 2) @(posedge clk);
        @(negedge clk);
        check("tx_pre_reset_low", serialOut, 1'b0);
        reset = 1'b0;
        #1 check("reset_async_serialOut", serialOut, 1'b1);
        check("reset_irq", irq, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        readCheck("post_reset_status", 2'd1, 8'h0C);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("post_reset_line_idle", serialOut, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
